// File: rtl/stage_divider_pkg.sv
// Shared constants and types for the RV32M divide unit.
package stage_divider_pkg;

    localparam int WD_SIZE       = 32;
    localparam int REG_ADDR_SIZE = 5;
    localparam int OPCODE_SIZE   = 7;
    localparam int FUNCT7_SIZE   = 7;
    localparam int FUNCT3_SIZE   = 3;

    localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = 7'b0110011;
    localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = 7'b0000001;

    localparam logic [FUNCT3_SIZE-1:0] F3_DIV  = 3'b100;
    localparam logic [FUNCT3_SIZE-1:0] F3_DIVU = 3'b101;
    localparam logic [FUNCT3_SIZE-1:0] F3_REM  = 3'b110;
    localparam logic [FUNCT3_SIZE-1:0] F3_REMU = 3'b111;

    // One quotient bit per DIVIDE cycle.
    localparam int DIV_CYCLES = WD_SIZE;

    // Divider FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] div_state_t;
    localparam div_state_t ST_IDLE   = 2'd0;
    localparam div_state_t ST_DIVIDE = 2'd1;
    localparam div_state_t ST_FIX    = 2'd2;
    localparam div_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/stage_divider_step.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_iter_step #(
    parameter int WD_SIZE = 32
) (
    input  logic [WD_SIZE-1:0] i_rem,
    input  logic [WD_SIZE-1:0] i_dvd,
    input  logic [WD_SIZE-1:0] i_dsr,
    output logic [WD_SIZE-1:0] o_rem,
    output logic [WD_SIZE-1:0] o_dvd,
    output logic               o_qbit
);

    logic [WD_SIZE:0] w_part;
    logic [WD_SIZE:0] w_diff;
    logic             w_unused_diff_msb;

    // Full WD+1 width so a partial remainder with its top bit set still
    // compares correctly against a large divisor.
    assign w_part = {i_rem, i_dvd[WD_SIZE-1]};
    assign w_diff = w_part - {1'b0, i_dsr};
    assign o_qbit = (w_part >= {1'b0, i_dsr});

    // When the subtraction is taken the difference is below the divisor,
    // so its top bit is always zero.
    assign w_unused_diff_msb = w_diff[WD_SIZE];
    assign o_rem = o_qbit ? w_diff[WD_SIZE-1:0] : w_part[WD_SIZE-1:0];
    // Quotient bit is inserted into the vacated LSB by the caller.
    assign o_dvd = {i_dvd[WD_SIZE-2:0], 1'b0};

endmodule

// File: rtl/stage_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring radix-2, one bit
// per cycle. Stalls the pipeline via busy_o while an operation is in flight.
module stage_divider #(
    parameter int WD_SIZE       = stage_divider_pkg::WD_SIZE,
    parameter int REG_ADDR_SIZE = stage_divider_pkg::REG_ADDR_SIZE
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    valid_i,
    input  logic [stage_divider_pkg::OPCODE_SIZE-1:0] opcode_i,
    input  logic [stage_divider_pkg::FUNCT7_SIZE-1:0] funct7_i,
    input  logic [stage_divider_pkg::FUNCT3_SIZE-1:0] funct3_i,
    input  logic [WD_SIZE-1:0]                      op1_data_i,
    input  logic [WD_SIZE-1:0]                      op2_data_i,
    input  logic [REG_ADDR_SIZE-1:0]                rd_i,
    input  logic                                    flush_i,
    output logic                                    busy_o,
    output logic                                    valid_o,
    output logic [WD_SIZE-1:0]                      result_o,
    output logic [REG_ADDR_SIZE-1:0]                rd_o
);

    import stage_divider_pkg::*;

    localparam int CW = $clog2(WD_SIZE);
    localparam logic [WD_SIZE-1:0] MSB_ONLY = {1'b1, {(WD_SIZE-1){1'b0}}};
    localparam logic [WD_SIZE-1:0] ALL_ONES = '1;

    div_state_t                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [WD_SIZE-1:0]         r_rem;
    logic [WD_SIZE-1:0]         r_dvd;      // dividend, becomes the quotient
    logic [WD_SIZE-1:0]         r_dsr;
    logic [WD_SIZE-1:0]         r_result;
    logic [REG_ADDR_SIZE-1:0]   r_rd_lat;
    logic [REG_ADDR_SIZE-1:0]   r_rd;
    logic                       r_is_rem;
    logic                       r_neg_q;
    logic                       r_neg_r;

    logic                       w_req;
    logic                       w_signed;
    logic                       w_op1_neg;
    logic                       w_op2_neg;
    logic [WD_SIZE-1:0]         w_abs1;
    logic [WD_SIZE-1:0]         w_abs2;
    logic                       w_div0;
    logic                       w_ovf;
    logic [WD_SIZE-1:0]         w_special_res;
    logic [WD_SIZE-1:0]         w_rem_nx;
    logic [WD_SIZE-1:0]         w_dvd_nx;
    logic                       w_qbit;
    logic [WD_SIZE-1:0]         w_quo_fix;
    logic [WD_SIZE-1:0]         w_rem_fix;
    logic [WD_SIZE-1:0]         w_fix_res;

    assign w_req     = valid_i && (opcode_i == OPCODE_OP) &&
                       (funct7_i == F7_MULDIV) && funct3_i[2];
    assign w_signed  = ~funct3_i[0];
    assign w_op1_neg = w_signed & op1_data_i[WD_SIZE-1];
    assign w_op2_neg = w_signed & op2_data_i[WD_SIZE-1];
    // Negating 0x80000000 wraps back to itself, which is the right magnitude
    // when read as unsigned.
    assign w_abs1    = w_op1_neg ? -op1_data_i : op1_data_i;
    assign w_abs2    = w_op2_neg ? -op2_data_i : op2_data_i;

    assign w_div0    = (op2_data_i == '0);
    assign w_ovf     = w_signed && (op1_data_i == MSB_ONLY) && (op2_data_i == ALL_ONES);
    // Divide-by-zero wins over overflow (the two cannot coincide anyway).
    assign w_special_res = funct3_i[1] ? (w_div0 ? op1_data_i : '0)
                                       : (w_div0 ? ALL_ONES   : MSB_ONLY);

    div_iter_step #(.WD_SIZE(WD_SIZE)) u_step (
        .i_rem  (r_rem),
        .i_dvd  (r_dvd),
        .i_dsr  (r_dsr),
        .o_rem  (w_rem_nx),
        .o_dvd  (w_dvd_nx),
        .o_qbit (w_qbit)
    );

    assign w_quo_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
    assign w_fix_res = r_is_rem ? w_rem_fix : w_quo_fix;

    // Divider FSM and datapath; output registers only load on entry to DONE
    // so result_o/rd_o hold their previous values otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_result <= '0;
            r_rd_lat <= '0;
            r_rd     <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !flush_i) begin
                        r_rd_lat <= rd_i;
                        r_is_rem <= funct3_i[1];
                        r_neg_q  <= w_op1_neg ^ w_op2_neg;
                        r_neg_r  <= w_op1_neg;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_rd     <= rd_i;
                            r_state  <= ST_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_dvd   <= w_abs1;
                            r_dsr   <= w_abs2;
                            r_cnt   <= CW'(DIV_CYCLES - 1);
                            r_state <= ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_dvd <= w_dvd_nx | {{(WD_SIZE-1){1'b0}}, w_qbit};
                        if (r_cnt == '0) r_state <= ST_FIX;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_rd     <= r_rd_lat;
                        r_state  <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = (r_state != ST_IDLE);
    // A flush arriving during DONE still kills the writeback that cycle.
    assign valid_o  = (r_state == ST_DONE) && !flush_i;
    assign result_o = r_result;
    assign rd_o     = r_rd;

endmodule

// File: tb/tb_stage_divider.sv
// Randomised self-checking bench for stage_divider against an arithmetic
// reference of the RV32M divide rules.
module tb_stage_divider;

    import stage_divider_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_data_i;
    logic [31:0] op2_data_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    stage_divider dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_i    (valid_i),
        .opcode_i   (opcode_i),
        .funct7_i   (funct7_i),
        .funct3_i   (funct3_i),
        .op1_data_i (op1_data_i),
        .op2_data_i (op2_data_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .rd_o       (rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension results from plain arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int  sa;
        int  sb;
        bit  ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        valid_i    = 1'b1;
        opcode_i   = OPCODE_OP;
        funct7_i   = F7_MULDIV;
        funct3_i   = f3;
        op1_data_i = a;
        op2_data_i = b;
        rd_i       = rd;
    endtask

    // Present one request for one edge, then drop valid_i.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        drive(f3, a, b, rd);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Wait for valid_o; n counts the cycle after acceptance (1 = T+1).
    task automatic wait_result(output int n, output int bad_busy);
        n = 1;
        bad_busy = 0;
        while (!valid_o && n < 60) begin
            if (!busy_o) bad_busy++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int n;
        int bad_busy;
        issue(f3, a, b, rd);
        wait_result(n, bad_busy);
        chk({tag, "_lat"}, n, ref_lat(f3, a, b));
        chk({tag, "_res"}, result_o, ref_res(f3, a, b));
        chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
        chk({tag, "_busy"}, bad_busy + {31'd0, ~busy_o}, 0);
        @(posedge clk); #1;
        chk({tag, "_after"}, {30'd0, valid_o, busy_o}, 0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid_o) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        int n;
        int bad_busy;
        int extra;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        reset_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        opcode_i = '0; funct7_i = '0; funct3_i = '0;
        op1_data_i = '0; op2_data_i = '0; rd_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_result", result_o, 0);
        chk("rst_rd", {27'd0, rd_o}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("div_20_m3",  F3_DIV,  32'd20, 32'hFFFF_FFFD, 5'd5);
        run_op("rem_20_m3",  F3_REM,  32'd20, 32'hFFFF_FFFD, 5'd6);
        run_op("divu_max_2", F3_DIVU, 32'hFFFF_FFFF, 32'd2, 5'd7);
        run_op("remu_max_2", F3_REMU, 32'hFFFF_FFFF, 32'd2, 5'd8);
        run_op("rem_m7_2",   F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd9);
        run_op("div_7_0",    F3_DIV,  32'd7, 32'd0, 5'd10);
        run_op("remu_7_0",   F3_REMU, 32'd7, 32'd0, 5'd11);
        run_op("div_ovf",    F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("rem_ovf",    F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op("divu_ovfop", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        run_op("div_0_5",    F3_DIV,  32'd0, 32'd5, 5'd15);
        run_op("div_min_3",  F3_DIV,  32'h8000_0000, 32'd3, 5'd16);
        run_op("remu_big",   F3_REMU, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 5'd17);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = $urandom_range(0, 100);
                    b = $urandom_range(1, 10);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: begin a = 32'd0; b = $urandom | 32'd1; end
                4: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom));
        end

        // Request held while busy: ignored until the first IDLE cycle.
        issue(F3_DIV, 32'd100, 32'd7, 5'd1);
        drive(F3_REMU, 32'd1000, 32'd33, 5'd2);
        bad_busy = 0;
        extra = 0;
        for (int k = 1; k <= 34; k++) begin
            if (!busy_o) bad_busy++;
            if (k < 34 && valid_o) extra++;
            if (k == 34) begin
                chk("hold_first_valid", {31'd0, valid_o}, 1);
                chk("hold_first_res", result_o, ref_res(F3_DIV, 32'd100, 32'd7));
                chk("hold_first_rd", {27'd0, rd_o}, 1);
            end
            @(posedge clk); #1;
        end
        chk("hold_busy", bad_busy, 0);
        chk("hold_extra_valid", extra, 0);
        chk("hold_idle_t35", {31'd0, busy_o}, 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_result(n, bad_busy);
        chk("hold_second_lat", n, 34);
        chk("hold_second_res", result_o, ref_res(F3_REMU, 32'd1000, 32'd33));
        chk("hold_second_rd", {27'd0, rd_o}, 2);
        @(posedge clk); #1;

        // Flush during DIVIDE at T+10
        issue(F3_DIV, 32'd12345, 32'd17, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_busy_t11", {31'd0, busy_o}, 0);
        watch_quiet("flush_no_valid", 40);

        // Flush during DONE suppresses valid_o that cycle
        issue(F3_DIV, 32'd7, 32'd0, 5'd4);
        flush_i = 1'b1;
        #1;
        chk("flush_done_valid", {31'd0, valid_o}, 0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_done_busy", {31'd0, busy_o}, 0);

        // Flush together with a request in IDLE: not accepted
        drive(F3_DIVU, 32'd50, 32'd5, 5'd5);
        flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_idle_busy", {31'd0, busy_o}, 0);
        watch_quiet("flush_idle_no_valid", 5);

        // Reset mid-operation at T+20
        issue(F3_DIVU, 32'd999, 32'd3, 5'd9);
        repeat (19) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_outs", {result_o[25:0], rd_o, valid_o, busy_o}, 0);
        chk("rst_mid_result", result_o, 0);
        reset_n = 1'b1;
        watch_quiet("rst_mid_no_valid", 40);

        // Non-divide instruction (MUL) is ignored
        drive(3'b000, 32'd6, 32'd7, 5'd1);
        @(posedge clk); #1;
        chk("mul_busy", {31'd0, busy_o}, 0);
        valid_i = 1'b0;
        watch_quiet("mul_no_valid", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
